// File: rtl/npu_sram_pkg.sv
// Shared definitions for the output-SRAM read path.
// Contents:
//   SramMaxAddrWidth, SramWidthO, SramLenWidth  default widths for the read port
//   rd_state_e                                  burst sequencer state encoding
package npu_sram_pkg;

  localparam int unsigned SramMaxAddrWidth = 13;
  localparam int unsigned SramWidthO       = 8;
  // One extra bit so a burst can cover the whole address space.
  localparam int unsigned SramLenWidth     = SramMaxAddrWidth + 1;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StBurst = 2'd1,
    StDrain = 2'd2
  } rd_state_e;

endpackage

// File: rtl/rd_skid_fifo2.sv
// Two-entry FIFO used as the response skid buffer of the output-SRAM reader.
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   push        write push_data this cycle (caller guarantees room, or a same-cycle pop)
//   push_data   entry to store
//   pop         consume the head entry (ignored while empty)
//   pop_data    head entry, held stable until popped
//   count       number of stored entries (0..2)
//   full        two entries stored
//   empty       no entries stored
module rd_skid_fifo2 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [1:0]       count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic             do_pop;

  assign do_pop   = pop && (count_q != 2'd0);
  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign full     = (count_q == 2'd2);
  assign empty    = (count_q == 2'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      // When full, a push is only legal alongside a pop; it lands in the slot being freed.
      if (push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/sram_out_rd_arbiter.sv
// Round-robin arbiter and burst sequencer for the single read port of the output SRAM.
// Each requester posts a burst (base, len); one SRAM read is issued per cycle and the words
// come back through a 2-entry skid buffer tagged with the owner id and a last flag.
// Ports:
//   clk, rst           clock and synchronous active-high reset
//   req_valid          per-requester burst request
//   req_ready          one-cycle one-hot accept pulse
//   req_base, req_len  packed per-requester start address / length (requester i at slice i)
//   sram_out_en        SRAM read enable
//   sram_out_addr      SRAM read address (0 when not reading)
//   sram_out_data_out  SRAM read data, valid the cycle after sram_out_en
//   rsp_valid          response word available
//   rsp_ready          response word consumed
//   rsp_data           response word
//   rsp_id             requester owning rsp_data
//   rsp_last           final word of the burst
//   busy               sequencer not idle
module sram_out_rd_arbiter
  import npu_sram_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned MAX_ADDR_WIDTH = SramMaxAddrWidth,
  parameter int unsigned SRAM_WIDTH_O   = SramWidthO,
  parameter int unsigned LEN_WIDTH      = SramLenWidth
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [NUM_REQ*MAX_ADDR_WIDTH-1:0] req_base,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]      req_len,
  output logic                              sram_out_en,
  output logic [MAX_ADDR_WIDTH-1:0]         sram_out_addr,
  input  logic [SRAM_WIDTH_O-1:0]           sram_out_data_out,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [SRAM_WIDTH_O-1:0]           rsp_data,
  output logic [$clog2(NUM_REQ)-1:0]        rsp_id,
  output logic                              rsp_last,
  output logic                              busy
);

  localparam int unsigned IdW    = $clog2(NUM_REQ);
  localparam int unsigned EntryW = IdW + 1 + SRAM_WIDTH_O;

  function automatic logic [IdW-1:0] ptr_inc(input logic [IdW-1:0] p);
    if (p == IdW'(NUM_REQ - 1)) return '0;
    return p + IdW'(1);
  endfunction

  rd_state_e                 state_q;
  logic [NUM_REQ-1:0]        req_ready_q;
  logic [IdW-1:0]            rr_ptr_q;
  logic [IdW-1:0]            id_q;
  logic [MAX_ADDR_WIDTH-1:0] base_q;
  logic [LEN_WIDTH-1:0]      len_q;
  logic [LEN_WIDTH-1:0]      issued_q;
  logic                      inflight_q;
  logic                      inflight_last_q;
  logic [IdW-1:0]            inflight_id_q;

  // Round-robin scan starting at rr_ptr_q.
  logic           grant_found;
  logic [IdW-1:0] grant_idx;
  logic [IdW:0]   scan_sum;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_sum    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      scan_sum = {1'b0, rr_ptr_q} + (IdW + 1)'(i);
      if (scan_sum >= (IdW + 1)'(NUM_REQ)) begin
        scan_sum = scan_sum - (IdW + 1)'(NUM_REQ);
      end
      if (!grant_found && req_valid[scan_sum[IdW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = scan_sum[IdW-1:0];
      end
    end
  end

  logic [MAX_ADDR_WIDTH-1:0] sel_base;
  logic [LEN_WIDTH-1:0]      sel_len;

  assign sel_base = req_base[grant_idx * MAX_ADDR_WIDTH +: MAX_ADDR_WIDTH];
  assign sel_len  = req_len[grant_idx * LEN_WIDTH +: LEN_WIDTH];

  // Skid buffer and credit accounting.
  logic [1:0]        fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic              fifo_push;
  logic [EntryW-1:0] fifo_rdata;
  logic [2:0]        occupancy;
  logic              issue;
  logic              issue_last;

  assign fifo_pop  = rsp_ready && !fifo_empty;
  assign fifo_push = inflight_q && (!fifo_full || fifo_pop);

  // Words already held or in flight, net of the one leaving this cycle. Counting the
  // departing word keeps a 1 word/cycle stream going with only two buffer slots.
  assign occupancy  = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, fifo_pop};
  assign issue      = (state_q == StBurst) && (issued_q < len_q) && (occupancy < 3'd2);
  assign issue_last = issue && (issued_q == len_q - LEN_WIDTH'(1));

  assign sram_out_en   = issue;
  assign sram_out_addr = issue ? base_q + issued_q[MAX_ADDR_WIDTH-1:0] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      req_ready_q     <= '0;
      rr_ptr_q        <= '0;
      id_q            <= '0;
      base_q          <= '0;
      len_q           <= '0;
      issued_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      inflight_id_q   <= '0;
    end else begin
      req_ready_q     <= '0;
      inflight_q      <= issue;
      inflight_last_q <= issue_last;
      inflight_id_q   <= id_q;
      case (state_q)
        StIdle: begin
          // Skip the cycle showing an accept pulse so the accepted requester can drop valid.
          if (grant_found && (req_ready_q == '0)) begin
            req_ready_q[grant_idx] <= 1'b1;
            base_q                 <= sel_base;
            len_q                  <= sel_len;
            id_q                   <= grant_idx;
            issued_q               <= '0;
            if (sel_len == '0) begin
              rr_ptr_q <= ptr_inc(grant_idx);
            end else begin
              state_q <= StBurst;
            end
          end
        end
        StBurst: begin
          if (issue) begin
            issued_q <= issued_q + LEN_WIDTH'(1);
            if (issue_last) state_q <= StDrain;
          end
        end
        StDrain: begin
          if (!inflight_q && fifo_empty) begin
            rr_ptr_q <= ptr_inc(id_q);
            state_q  <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  rd_skid_fifo2 #(
    .WIDTH(EntryW)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .push_data({inflight_id_q, inflight_last_q, sram_out_data_out}),
    .pop      (fifo_pop),
    .pop_data (fifo_rdata),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign req_ready                    = req_ready_q;
  assign rsp_valid                    = !fifo_empty;
  assign {rsp_id, rsp_last, rsp_data} = fifo_rdata;
  assign busy                         = (state_q != StIdle);

endmodule

// File: tb/tb_sram_out_rd_arbiter.sv
module tb_sram_out_rd_arbiter;

  localparam int NR = 2;
  localparam int AW = 13;
  localparam int DW = 8;
  localparam int LW = 14;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NR-1:0]    req_valid = '0;
  logic [NR-1:0]    req_ready;
  logic [NR*AW-1:0] req_base = '0;
  logic [NR*LW-1:0] req_len = '0;
  logic             sram_out_en;
  logic [AW-1:0]    sram_out_addr;
  logic [DW-1:0]    sram_out_data_out = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b1;
  logic [DW-1:0]    rsp_data;
  logic [0:0]       rsp_id;
  logic             rsp_last;
  logic             busy;

  always #5 clk = ~clk;

  sram_out_rd_arbiter #(
    .NUM_REQ       (NR),
    .MAX_ADDR_WIDTH(AW),
    .SRAM_WIDTH_O  (DW),
    .LEN_WIDTH     (LW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_base         (req_base),
    .req_len          (req_len),
    .sram_out_en      (sram_out_en),
    .sram_out_addr    (sram_out_addr),
    .sram_out_data_out(sram_out_data_out),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_data         (rsp_data),
    .rsp_id           (rsp_id),
    .rsp_last         (rsp_last),
    .busy             (busy)
  );

  function automatic logic [7:0] mdata(input logic [12:0] a);
    return a[7:0] ^ {3'b101, a[12:8]};
  endfunction

  function automatic logic [9:0] word(input bit id, input bit last, input int addr);
    logic [12:0] a;
    a = AW'(addr);
    return {id, last, mdata(a)};
  endfunction

  // SRAM with one cycle of read latency.
  always @(posedge clk) begin
    if (sram_out_en) sram_out_data_out <= mdata(sram_out_addr);
  end

  // Monitor: logs reads, transfers and grants; tracks words issued but not yet consumed.
  int         cyc = 0;
  int         occ = 0;
  int         credit_err = 0;
  int         addr_err = 0;
  int         stab_err = 0;
  int         onehot_err = 0;
  int         busy_cnt = 0;
  bit         prev_stall = 0;
  logic [9:0] prev_word = '0;
  logic [1:0] seen_ready = '0;
  int         en_addr[$];
  int         en_cyc[$];
  logic [9:0] rsp_w[$];
  int         rsp_cyc[$];
  logic [1:0] grants[$];
  int         rdy_cyc[$];

  always @(negedge clk) begin
    int pop;
    cyc++;
    seen_ready = req_ready;
    if (rst) begin
      occ        = 0;
      prev_stall = 0;
    end else begin
      pop = (rsp_valid && rsp_ready) ? 1 : 0;
      if (busy) busy_cnt++;
      if (sram_out_en) begin
        en_addr.push_back(int'(sram_out_addr));
        en_cyc.push_back(cyc);
        if (occ - pop >= 2) credit_err++;
      end else if (sram_out_addr != '0) begin
        addr_err++;
      end
      if (prev_stall && (!rsp_valid || {rsp_id, rsp_last, rsp_data} !== prev_word)) stab_err++;
      prev_stall = rsp_valid && !rsp_ready;
      prev_word  = {rsp_id, rsp_last, rsp_data};
      if (pop == 1) begin
        rsp_w.push_back({rsp_id, rsp_last, rsp_data});
        rsp_cyc.push_back(cyc);
      end
      if (req_ready != '0) begin
        if (req_ready == 2'b11) onehot_err++;
        grants.push_back(req_ready);
        rdy_cyc.push_back(cyc);
      end
      occ = occ + (sram_out_en ? 1 : 0) - pop;
    end
  end

  int       n_tests = 0;
  int       n_fail = 0;
  bit       bp_en = 0;
  int       bp_phase = 0;
  bit [3:0] bp_pat = 4'b1001;

  // Advance one cycle; requesters drop valid once their accept pulse has been seen.
  task automatic tick();
    @(posedge clk);
    #1;
    req_valid = req_valid & ~seen_ready;
    if (bp_en) begin
      rsp_ready = bp_pat[bp_phase];
      bp_phase  = (bp_phase + 1) % 4;
    end
  endtask

  task automatic start_req(input int idx, input int base, input int len);
    req_base[idx*AW +: AW] = AW'(base);
    req_len[idx*LW +: LW]  = LW'(len);
    req_valid[idx]         = 1'b1;
  endtask

  task automatic run(input int maxc, output bit to);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while ((busy || rsp_valid || req_valid != '0) && n < maxc);
    to = busy || rsp_valid || (req_valid != '0);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_tests++;
    if ({req_ready, sram_out_en, sram_out_addr} !== '0) begin
      n_fail++;
      $display("FAIL reset_req_sram: got %b/%b/%0d required 0", req_ready, sram_out_en,
               sram_out_addr);
    end
    n_tests++;
    if ({rsp_valid, rsp_data, rsp_id, rsp_last} !== '0) begin
      n_fail++;
      $display("FAIL reset_rsp: got v=%b d=%h id=%b l=%b required 0", rsp_valid, rsp_data,
               rsp_id, rsp_last);
    end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy: got %b required 0", busy);
    end
    rst = 1'b0;
    tick();
    tick();
    n_tests++;
    if ({busy, sram_out_en, rsp_valid, req_ready} !== '0) begin
      n_fail++;
      $display("FAIL reset_idle: got busy=%b en=%b v=%b rdy=%b required 0", busy, sram_out_en,
               rsp_valid, req_ready);
    end
  endtask

  task automatic test_single();
    int s_en, s_rsp, s_gr, got;
    bit to;
    logic [9:0] w;
    s_en = en_addr.size(); s_rsp = rsp_w.size(); s_gr = grants.size();
    start_req(0, 5, 4);
    run(40, to);
    n_tests++;
    if (to || en_addr.size() - s_en != 4 || rsp_w.size() - s_rsp != 4) begin
      n_fail++;
      $display("FAIL single_count: got en=%0d rsp=%0d busy=%b required 4/4/idle",
               en_addr.size() - s_en, rsp_w.size() - s_rsp, busy);
    end else begin
      for (int k = 0; k < 4; k++) begin
        got = en_addr[s_en+k];
        n_tests++;
        if (got != 5 + k) begin
          n_fail++;
          $display("FAIL single_addr%0d: got %0d required %0d", k, got, 5 + k);
        end
        w = rsp_w[s_rsp+k];
        n_tests++;
        if (w !== word(1'b0, k == 3, 5 + k)) begin
          n_fail++;
          $display("FAIL single_word%0d: got %h required %h", k, w, word(1'b0, k == 3, 5 + k));
        end
      end
      n_tests++;
      if (en_cyc[s_en+3] - en_cyc[s_en] != 3) begin
        n_fail++;
        $display("FAIL single_consecutive: got span %0d required 3",
                 en_cyc[s_en+3] - en_cyc[s_en]);
      end
      n_tests++;
      if (grants.size() <= s_gr || rsp_cyc[s_rsp] - rdy_cyc[s_gr] != 2) begin
        n_fail++;
        $display("FAIL single_latency: got %0d required 2",
                 grants.size() > s_gr ? rsp_cyc[s_rsp] - rdy_cyc[s_gr] : -1);
      end
    end
  endtask

  task automatic test_contention();
    int s_rsp, s_gr;
    bit to;
    logic [9:0] exp_w[6];
    do_reset();
    s_rsp = rsp_w.size(); s_gr = grants.size();
    start_req(0, 100, 3);
    start_req(1, 200, 3);
    run(80, to);
    n_tests++;
    if (to || grants.size() - s_gr != 2 || rsp_w.size() - s_rsp != 6) begin
      n_fail++;
      $display("FAIL contend_count: got grants=%0d rsp=%0d required 2/6",
               grants.size() - s_gr, rsp_w.size() - s_rsp);
    end else begin
      n_tests++;
      if (grants[s_gr] !== 2'b01 || grants[s_gr+1] !== 2'b10) begin
        n_fail++;
        $display("FAIL contend_order: got %b,%b required 01,10", grants[s_gr], grants[s_gr+1]);
      end
      for (int k = 0; k < 3; k++) begin
        exp_w[k]   = word(1'b0, k == 2, 100 + k);
        exp_w[k+3] = word(1'b1, k == 2, 200 + k);
      end
      for (int k = 0; k < 6; k++) begin
        n_tests++;
        if (rsp_w[s_rsp+k] !== exp_w[k]) begin
          n_fail++;
          $display("FAIL contend_word%0d: got %h required %h", k, rsp_w[s_rsp+k], exp_w[k]);
        end
      end
    end
    // req0 alone moves the pointer to 1, so the next pair goes to req1 first.
    start_req(0, 10, 1);
    run(40, to);
    s_rsp = rsp_w.size(); s_gr = grants.size();
    start_req(0, 20, 2);
    start_req(1, 30, 2);
    run(80, to);
    n_tests++;
    if (to || grants.size() - s_gr != 2 || rsp_w.size() - s_rsp != 4) begin
      n_fail++;
      $display("FAIL contend2_count: got grants=%0d rsp=%0d required 2/4",
               grants.size() - s_gr, rsp_w.size() - s_rsp);
    end else begin
      n_tests++;
      if (grants[s_gr] !== 2'b10 || grants[s_gr+1] !== 2'b01) begin
        n_fail++;
        $display("FAIL contend2_order: got %b,%b required 10,01", grants[s_gr], grants[s_gr+1]);
      end
      n_tests++;
      if (rsp_w[s_rsp] !== word(1'b1, 1'b0, 30) || rsp_w[s_rsp+1] !== word(1'b1, 1'b1, 31)
          || rsp_w[s_rsp+2] !== word(1'b0, 1'b0, 20) || rsp_w[s_rsp+3] !== word(1'b0, 1'b1, 21))
      begin
        n_fail++;
        $display("FAIL contend2_words: got %h %h %h %h required %h %h %h %h", rsp_w[s_rsp],
                 rsp_w[s_rsp+1], rsp_w[s_rsp+2], rsp_w[s_rsp+3], word(1'b1, 1'b0, 30),
                 word(1'b1, 1'b1, 31), word(1'b0, 1'b0, 20), word(1'b0, 1'b1, 21));
      end
    end
  endtask

  task automatic test_backpressure();
    int s_en, s_rsp;
    bit to;
    s_en = en_addr.size(); s_rsp = rsp_w.size();
    bp_phase  = 1;
    rsp_ready = bp_pat[0];
    bp_en     = 1;
    start_req(0, 300, 6);
    run(120, to);
    bp_en     = 0;
    rsp_ready = 1'b1;
    n_tests++;
    if (to || en_addr.size() - s_en != 6 || rsp_w.size() - s_rsp != 6) begin
      n_fail++;
      $display("FAIL bp_count: got en=%0d rsp=%0d required 6/6", en_addr.size() - s_en,
               rsp_w.size() - s_rsp);
    end else begin
      for (int k = 0; k < 6; k++) begin
        n_tests++;
        if (rsp_w[s_rsp+k] !== word(1'b0, k == 5, 300 + k)) begin
          n_fail++;
          $display("FAIL bp_word%0d: got %h required %h", k, rsp_w[s_rsp+k],
                   word(1'b0, k == 5, 300 + k));
        end
      end
      n_tests++;
      if (en_cyc[s_en+5] - en_cyc[s_en] <= 5) begin
        n_fail++;
        $display("FAIL bp_stall: got issue span %0d required >5", en_cyc[s_en+5] - en_cyc[s_en]);
      end
    end
    n_tests++;
    if (stab_err != 0) begin
      n_fail++;
      $display("FAIL bp_stable: got %0d unstable cycles required 0", stab_err);
    end
    n_tests++;
    if (credit_err != 0) begin
      n_fail++;
      $display("FAIL bp_credit: got %0d over-issues required 0", credit_err);
    end
  endtask

  task automatic test_wrap();
    int s_en, s_rsp, ea;
    bit to;
    s_en = en_addr.size(); s_rsp = rsp_w.size();
    start_req(0, 8190, 4);
    run(40, to);
    n_tests++;
    if (to || en_addr.size() - s_en != 4 || rsp_w.size() - s_rsp != 4) begin
      n_fail++;
      $display("FAIL wrap_count: got en=%0d rsp=%0d required 4/4", en_addr.size() - s_en,
               rsp_w.size() - s_rsp);
    end else begin
      for (int k = 0; k < 4; k++) begin
        ea = (8190 + k) % 8192;
        n_tests++;
        if (en_addr[s_en+k] != ea || rsp_w[s_rsp+k] !== word(1'b0, k == 3, ea)) begin
          n_fail++;
          $display("FAIL wrap_%0d: got addr %0d word %h required %0d %h", k, en_addr[s_en+k],
                   rsp_w[s_rsp+k], ea, word(1'b0, k == 3, ea));
        end
      end
    end
  endtask

  task automatic test_len0();
    int s_en, s_rsp, s_gr, s_busy;
    bit to;
    s_en = en_addr.size(); s_rsp = rsp_w.size(); s_gr = grants.size(); s_busy = busy_cnt;
    start_req(1, 77, 0);
    run(20, to);
    tick(); tick(); tick();
    n_tests++;
    if (to || grants.size() - s_gr != 1 || (grants.size() > s_gr && grants[s_gr] !== 2'b10)) begin
      n_fail++;
      $display("FAIL len0_pulse: got %0d pulses required 1 on req1", grants.size() - s_gr);
    end
    n_tests++;
    if (en_addr.size() != s_en || rsp_w.size() != s_rsp || busy_cnt != s_busy) begin
      n_fail++;
      $display("FAIL len0_quiet: got en=%0d rsp=%0d busy=%0d required 0/0/0",
               en_addr.size() - s_en, rsp_w.size() - s_rsp, busy_cnt - s_busy);
    end
    // Pointer must now be 0: a simultaneous pair is served req0 first.
    s_gr = grants.size();
    start_req(0, 60, 1);
    start_req(1, 70, 1);
    run(40, to);
    n_tests++;
    if (to || grants.size() - s_gr != 2 || grants[s_gr] !== 2'b01) begin
      n_fail++;
      $display("FAIL len0_ptr: got first grant %b required 01",
               grants.size() > s_gr ? grants[s_gr] : 2'b00);
    end
  endtask

  task automatic test_reset_mid();
    int s_en, s_rsp, n;
    bit to;
    s_rsp = rsp_w.size();
    start_req(0, 400, 5);
    n = 0;
    while (rsp_w.size() - s_rsp < 2 && n < 30) begin
      tick();
      n++;
    end
    n_tests++;
    if (rsp_w.size() - s_rsp < 2) begin
      n_fail++;
      $display("FAIL rstmid_progress: got %0d words required 2", rsp_w.size() - s_rsp);
    end
    rst = 1'b1;
    tick();
    n_tests++;
    if ({req_ready, sram_out_en, sram_out_addr, rsp_valid, rsp_data, rsp_id, rsp_last, busy}
        !== '0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: got en=%b addr=%0d v=%b d=%h busy=%b required all 0",
               sram_out_en, sram_out_addr, rsp_valid, rsp_data, busy);
    end
    rst = 1'b0;
    tick();
    s_en = en_addr.size(); s_rsp = rsp_w.size();
    start_req(1, 50, 3);
    run(40, to);
    n_tests++;
    if (to || en_addr.size() - s_en != 3 || rsp_w.size() - s_rsp != 3) begin
      n_fail++;
      $display("FAIL rstmid_fresh_count: got en=%0d rsp=%0d required 3/3",
               en_addr.size() - s_en, rsp_w.size() - s_rsp);
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_tests++;
        if (rsp_w[s_rsp+k] !== word(1'b1, k == 2, 50 + k)) begin
          n_fail++;
          $display("FAIL rstmid_word%0d: got %h required %h", k, rsp_w[s_rsp+k],
                   word(1'b1, k == 2, 50 + k));
        end
      end
    end
  endtask

  task automatic test_invariants();
    n_tests++;
    if (addr_err != 0) begin
      n_fail++;
      $display("FAIL addr_idle_zero: got %0d nonzero cycles required 0", addr_err);
    end
    n_tests++;
    if (onehot_err != 0) begin
      n_fail++;
      $display("FAIL ready_onehot: got %0d multi-hot cycles required 0", onehot_err);
    end
    n_tests++;
    if (credit_err != 0 || stab_err != 0) begin
      n_fail++;
      $display("FAIL global_flow: got credit=%0d stable=%0d required 0/0", credit_err, stab_err);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_wrap();
    test_len0();
    test_reset_mid();
    test_invariants();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
